// File: rtl/block_sync_rx_pkg.sv
// Shared 64b/66b PCS definitions: sync header encodings, the block-sync
// state type and default window sizes, which the high-BER monitor also uses.
package block_sync_rx_pkg;

    // Legal 2-bit sync headers: data block and control block.
    localparam logic [1:0] SYNC_DATA = 2'b01;
    localparam logic [1:0] SYNC_CTRL = 2'b10;

    // Default test-window length and invalid-header threshold.
    localparam int DEF_CNT_N   = 64;
    localparam int DEF_INV_MAX = 16;

    // Block-lock controller states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TEST = 2'd1,
        SLIP = 2'd2,
        WAIT = 2'd3
    } block_sync_state_e;

    // A header is legal only when its two bits differ.
    function automatic logic sync_hdr_valid(input logic [1:0] head);
        return (head == SYNC_DATA) || (head == SYNC_CTRL);
    endfunction

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        if (value == 16'hFFFF) begin
            return value;
        end else begin
            return value + 16'd1;
        end
    endfunction

endpackage

// File: rtl/block_sync_rx.sv
// Receive-side 64b/66b block-lock controller.
// Watches the sync header of every valid gearbox word, requests single-cycle
// slips until block boundaries are found, then drops lock when too many bad
// headers appear in one test window.
// Optional build macro BLOCK_SYNC_STATS_EN adds a saturating slip counter on
// slip_cnt_o; without it slip_cnt_o is constant zero.
module block_sync_rx
    import block_sync_rx_pkg::*;
#(
    parameter int HEAD_W    = 2,
    parameter int CNT_N     = DEF_CNT_N,
    parameter int INV_MAX   = DEF_INV_MAX,
    parameter int SLIP_WAIT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              signal_ok_i,
    input  logic              valid_i,
    input  logic [HEAD_W-1:0] head_i,
    output logic              slip_v_o,
    output logic              lock_o,
    output logic [15:0]       slip_cnt_o
);

    localparam int SH_W   = (CNT_N > 1) ? $clog2(CNT_N) : 1;
    localparam int INV_W  = $clog2(INV_MAX + 1);
    localparam int WAIT_W = (SLIP_WAIT > 1) ? $clog2(SLIP_WAIT) : 1;

    localparam logic [SH_W-1:0]   SH_LAST   = SH_W'(CNT_N - 1);
    localparam logic [INV_W-1:0]  INV_LIMIT = INV_W'(INV_MAX);
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(SLIP_WAIT - 1);

    block_sync_state_e  state_r;
    logic [SH_W-1:0]    sh_cnt_r;
    logic [INV_W-1:0]   inv_cnt_r;
    logic [WAIT_W-1:0]  wait_cnt_r;

    logic               head_ok_s;
    logic               window_end_s;
    logic [INV_W-1:0]   inv_next_s;
    logic               inv_limit_s;

    // Header decode and window/threshold comparisons for the current word.
    always_comb begin
        head_ok_s    = sync_hdr_valid(head_i[1:0]);
        window_end_s = (sh_cnt_r == SH_LAST);
        inv_next_s   = inv_cnt_r + INV_W'(1);
        if (!head_ok_s) begin
            inv_limit_s = (inv_next_s == INV_LIMIT);
        end else begin
            inv_limit_s = 1'b0;
        end
    end

    // Lock FSM with window counters and registered lock/slip outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= IDLE;
            sh_cnt_r   <= '0;
            inv_cnt_r  <= '0;
            wait_cnt_r <= '0;
            lock_o     <= 1'b0;
            slip_v_o   <= 1'b0;
        end else if (!signal_ok_i) begin
            // Losing the PMA signal abandons lock and any slip in flight.
            state_r    <= IDLE;
            sh_cnt_r   <= '0;
            inv_cnt_r  <= '0;
            wait_cnt_r <= '0;
            lock_o     <= 1'b0;
            slip_v_o   <= 1'b0;
        end else begin
            // The slip request is a one-cycle pulse unless re-armed below.
            slip_v_o <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (valid_i) begin
                        state_r   <= TEST;
                        sh_cnt_r  <= '0;
                        inv_cnt_r <= '0;
                    end
                end

                TEST: begin
                    if (valid_i) begin
                        if (!lock_o) begin
                            // Hunting: any bad header means the boundary is wrong.
                            if (!head_ok_s) begin
                                state_r   <= SLIP;
                                slip_v_o  <= 1'b1;
                                sh_cnt_r  <= '0;
                                inv_cnt_r <= '0;
                            end else if (window_end_s) begin
                                lock_o    <= 1'b1;
                                sh_cnt_r  <= '0;
                                inv_cnt_r <= '0;
                            end else begin
                                sh_cnt_r  <= sh_cnt_r + SH_W'(1);
                            end
                        end else begin
                            // Locked: the bad-header count is applied before
                            // the window-end decision, so a bad last header
                            // can still drop lock.
                            if (inv_limit_s) begin
                                lock_o    <= 1'b0;
                                state_r   <= SLIP;
                                slip_v_o  <= 1'b1;
                                sh_cnt_r  <= '0;
                                inv_cnt_r <= '0;
                            end else if (window_end_s) begin
                                sh_cnt_r  <= '0;
                                inv_cnt_r <= '0;
                            end else begin
                                sh_cnt_r  <= sh_cnt_r + SH_W'(1);
                                if (!head_ok_s) begin
                                    inv_cnt_r <= inv_next_s;
                                end
                            end
                        end
                    end
                end

                SLIP: begin
                    // Pulse cycle; the gearbox realigns during WAIT.
                    state_r    <= WAIT;
                    wait_cnt_r <= WAIT_LOAD;
                end

                WAIT: begin
                    if (valid_i) begin
                        if (wait_cnt_r == '0) begin
                            state_r   <= TEST;
                            sh_cnt_r  <= '0;
                            inv_cnt_r <= '0;
                        end else begin
                            wait_cnt_r <= wait_cnt_r - WAIT_W'(1);
                        end
                    end
                end

                default: begin
                    state_r    <= IDLE;
                    sh_cnt_r   <= '0;
                    inv_cnt_r  <= '0;
                    wait_cnt_r <= '0;
                    lock_o     <= 1'b0;
                end
            endcase
        end
    end

`ifdef BLOCK_SYNC_STATS_EN
    logic [15:0] slip_cnt_r;

    // Saturating slip statistic; only a hard reset clears it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slip_cnt_r <= 16'h0000;
        end else if (slip_v_o) begin
            slip_cnt_r <= sat_inc16(slip_cnt_r);
        end
    end

    assign slip_cnt_o = slip_cnt_r;
`else
    assign slip_cnt_o = 16'h0000;
`endif

endmodule

// File: doc/block_sync_rx.md
# block_sync_rx

Receive-side block-lock controller for the 64b/66b PCS. It sits directly after `gearbox_rx` and inspects each recovered 2-bit sync header. It issues single-cycle slip requests back to the gearbox until 66-bit block boundaries are found, then monitors header errors to detect loss of lock. Its `lock_o` qualifies all downstream descrambler/decoder traffic.

## Interface
- `HEAD_W`, 2: sync header width; only 2 is supported.
- `CNT_N`, 64: headers per test window.
- `INV_MAX`, 16: invalid headers within one locked window that drop lock.
- `SLIP_WAIT`, 2: cycles in which headers are ignored after a slip while the gearbox realigns; must be at least 1.

Ports:
- `clk`  in  1  the single clock. It is the gearbox clock.
- `reset`  in  1  asynchronous, active-high reset.
- `signal_ok_i`  in  1  PMA/CDR lock; low forces the unlocked state.
- `valid_i`  in  1  gearbox `valid_o`; the header is sampled only when high.
- `head_i`  in  HEAD_W  gearbox `head_o`.
- `slip_v_o`  out  1  slip request to gearbox `slip_v_i`; one-cycle pulse.
- `lock_o`  out  1  block lock achieved.
- `slip_cnt_o`  out  16  saturating slip count (see Configuration).

## Operation
- **Header validity:** a header is valid iff `head_i` is `2'b01` or `2'b10`, i.e. `^head_i == 1`.
- **Counters:**
  - `sh_cnt` is $clog2(CNT_N) bits and counts valid_i cycles in the current window.
  - `inv_cnt` is $clog2(INV_MAX+1) bits and counts invalid headers in the window.
- **States:**
  - IDLE: the reset state. Go to TEST when `signal_ok_i`=1; counters are cleared.
  - TEST, unlocked, `valid_i`=1:
    - Invalid header: go to SLIP and clear counters.
    - Valid header that is the CNT_N-th of the window: set `lock_o`, clear counters, stay in TEST.
    - Otherwise: `sh_cnt`++.
  - TEST, locked, `valid_i`=1:
    - Invalid header: `inv_cnt`++. If this makes `inv_cnt` equal INV_MAX, clear `lock_o`, go to SLIP and clear counters.
    - CNT_N-th header of the window without reaching INV_MAX: clear both counters and stay locked.
  - SLIP: one cycle. `slip_v_o`=1 in this cycle only, then go to WAIT with the wait counter loaded to SLIP_WAIT-1.
  - WAIT: headers are ignored. The counter decrements each cycle; at 0, go to TEST (unlocked).
- **valid_i low:** no counter change and no transition, in every state.
- **signal_ok_i low:** takes precedence over everything except reset. Next cycle the block is in IDLE with `lock_o`=0 and `slip_v_o`=0, counters are cleared, and any pending slip is dropped.
- **CNT_N-th header invalid while locked:** the invalid count is applied before the window-end decision.
- **Slip rate:** at most one slip per 2+SLIP_WAIT cycles.

## Timing
- **Reset values:** `lock_o`=0, `slip_v_o`=0, `slip_cnt_o`=0, state IDLE, all counters 0.
- **Registered outputs:** all outputs are registered; there is no combinational path from input to output.
- **Lock latency:** `lock_o` rises one cycle after the clock edge sampling the CNT_N-th consecutive valid header. From IDLE with continuous valid headers, the minimum is CNT_N+1 edges after `signal_ok_i` rises.
- **Slip latency:** `slip_v_o` is high in the cycle after the edge that sampled the offending header.
- **Unlock latency:** `lock_o` falls in that same cycle.
- **Mid-operation reset:** immediate asynchronous return to the reset values.

## Configuration
- **`BLOCK_SYNC_STATS_EN` defined:** `slip_cnt_o` increments on every cycle where `slip_v_o`=1 and saturates at 16'hFFFF. It clears only on `reset`, not on loss of `signal_ok_i`.
- **Undefined:** `slip_cnt_o` is tied to 0 and no counter logic is built.

## Structure
- **Shared PCS package:**
  - sync header constants `SYNC_DATA`=2'b01 and `SYNC_CTRL`=2'b10;
  - the state enum typedef `block_sync_state_e` (IDLE, TEST, SLIP, WAIT);
  - default CNT_N and INV_MAX constants, also used by the high-BER monitor.
- **Sub-modules:** none needed. Counters and the FSM are inline; the optional statistics counter is a small local saturating counter.

## Test plan
- **Lock from reset:** after reset, `signal_ok_i`=1 and 64 consecutive `head_i`=2'b01 with `valid_i`=1 -> no slip; `lock_o`=1 on the cycle after the 64th.
- **Slip:**
  - Stimulus: unlocked, header 2'b11 at the 10th word.
  - Response: `slip_v_o` pulses for exactly 1 cycle, then 2 ignored cycles, then the window restarts; a further 64 valid headers are needed to lock.
- **Loss of lock:**
  - Stimulus: locked, 15 invalid headers in one window.
  - Response: lock is held and the window resets; the 16th invalid header in the next window drops `lock_o` and pulses `slip_v_o`.
- **Qualification:** gaps with `valid_i`=0 interleaved inside a 64-header window -> lock still after exactly 64 valid samples; headers are ignored during `valid_i`=0.
- **Signal loss:** `signal_ok_i` deasserted while locked and during SLIP -> next cycle `lock_o`=0 and `slip_v_o`=0, IDLE; re-lock requires a full window.
- **Statistics:** with `BLOCK_SYNC_STATS_EN`, force 3 slips -> `slip_cnt_o`=3; the count survives `signal_ok_i` toggling and is 0 after `reset`.
